pipe_reg_m: RTL and testbench
=============================

Name: pipe_reg_m

Overview:
- Execute-to-memory pipeline register: captures execute-stage results each cycle and presents them to the memory stage.
- Also does three things on capture:
  - Derives the load length and store byte count.
  - Flags misaligned accesses and suppresses them.
  - Counts memory operations that pass through the register.
- Sits between the execute stage and the memory stage. Stall/bubble come from the pipeline control unit.

Parameters:
- NOP_INSTR, 32'h00000013, instruction word inserted on reset/bubble (addi x0,x0,0)
- CNT_W, 32, width of the memory-operation counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ctrl_stall_M  in  1  hold register contents
- ctrl_bubble_M  in  1  insert NOP on next edge
- regE_o_valid  in  1  execute slot holds a real instruction
- regE_o_instr  in  32  instruction word
- regE_o_pc  in  64  instruction PC
- execute_o_valE  in  64  ALU result / effective address
- regE_o_valB  in  64  store data (rs2 value)
- regE_o_load_type  in  3  load type, define.v encodings (`lb, `lh, `lw, `lwu, `ld, `lbu, `lhu)
- regE_o_mem_ren  in  1  instruction is a load
- regE_o_mem_wen  in  1  instruction is a store
- regE_o_store_type  in  2  0=sb 1=sh 2=sw 3=sd
- regE_o_wb_en  in  1  writes rd
- regE_o_rd  in  5  destination register
- regM_o_valid  out  1
- regM_o_instr  out  32
- regM_o_pc  out  64
- regM_o_valE  out  64
- regM_o_valB  out  64
- regM_o_load_type  out  3
- regM_o_mem_ren  out  1
- regM_o_mem_wen  out  1
- regM_o_mem_wmask  out  4  store byte count 1/2/4/8, or `zero_byte (0)
- regM_o_wb_en  out  1
- regM_o_rd  out  5
- regM_o_misalign  out  1  captured access was misaligned and suppressed
- regM_o_mem_ops  out  CNT_W  accepted load/store count

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-stall):
  - valid=0, instr=NOP_INSTR, pc=0, valE=0, valB=0, load_type=0.
  - ren=0, wen=0, wmask=0, wb_en=0, rd=0, misalign=0, mem_ops=0.
- Per rising edge, priority order:
  1. ctrl_stall_M=1: all outputs hold, including mem_ops. Stall wins over bubble when both are asserted.
  2. ctrl_bubble_M=1: load reset values into every field except mem_ops, which holds.
  3. Otherwise: capture. Latency is exactly one cycle from input to output.
- Capture, for a valid instruction (regE_o_valid=1):
  - Access length:
    - Loads: `lb/`lbu=1, `lh/`lhu=2, `lw/`lwu=4, `ld=8, any other encoding=0.
    - Stores: sb=1, sh=2, sw=4, sd=8.
  - Misaligned means length>1 and (addr & (length-1)) != 0, where addr = execute_o_valE[2:0].
  - Captured access flags:
    - mem_ren = regE_o_mem_ren & ~misaligned.
    - mem_wen = regE_o_mem_wen & ~misaligned.
    - mem_wmask = store length when captured mem_wen=1, else 0.
    - misalign = misaligned & (regE_o_mem_ren | regE_o_mem_wen).
  - When misalign=1, wb_en is forced to 0. The trap itself is handled downstream; this block only flags and suppresses.
  - regE_o_mem_ren and regE_o_mem_wen both 1 is illegal. Treat it as a store: ren forced 0, misalign computed from the store length.
  - All other fields are copied unmodified.
- Capture, for an invalid slot (regE_o_valid=0): identical to a bubble.
- mem_ops counter:
  - Increments by 1 on each capture edge where captured mem_ren or mem_wen is 1.
  - Wraps modulo 2^CNT_W with no saturation.
  - Not incremented on stall, bubble or misaligned accesses.
- Outputs are registered only; no combinational path from inputs to outputs.
- Width rules:
  - Addresses and data are full 64-bit, never truncated or sign-modified here; extension happens in the memory stage.
  - wmask upper values 9..15 are never produced.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release mid-cycle, then inject one instruction -> before release, instr=32'h00000013, valid=0, mem_ops=0, all enables 0. After release, capture starts on the first edge.
- Aligned sd: valid=1, wen=1, store_type=3, valE=64'h80001008, valB=64'hDEADBEEF_01234567 -> next cycle wen=1, wmask=8, valB unchanged, misalign=0, mem_ops=1.
- Misaligned lw: ren=1, load_type=`lw, valE=64'h80001002, wb_en=1 -> ren=0, wb_en=0, misalign=1, mem_ops unchanged. The same case with `lbu -> ren=1, misalign=0.
- Stall then bubble: capture sh at 0x...04 (wmask=2). Assert stall 2 cycles while inputs change -> outputs unchanged, mem_ops unchanged. Then stall+bubble together -> still hold. Then bubble alone -> NOP, valid=0, wmask=0, mem_ops retained.
- Counter wrap: CNT_W=4, issue 17 aligned loads back-to-back -> mem_ops reads 15 then 0 then 1.
- Async reset mid-stall: during a stalled sw, drop rst between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_reg_m.sv
// Execute-to-memory pipeline register: captures execute results, derives access
// length, suppresses misaligned loads/stores and counts accepted memory operations.
module pipe_reg_m #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_stall_M,
    input  logic             ctrl_bubble_M,
    input  logic             regE_o_valid,
    input  logic [31:0]      regE_o_instr,
    input  logic [63:0]      regE_o_pc,
    input  logic [63:0]      execute_o_valE,
    input  logic [63:0]      regE_o_valB,
    input  logic [2:0]       regE_o_load_type,
    input  logic             regE_o_mem_ren,
    input  logic             regE_o_mem_wen,
    input  logic [1:0]       regE_o_store_type,
    input  logic             regE_o_wb_en,
    input  logic [4:0]       regE_o_rd,
    output logic             regM_o_valid,
    output logic [31:0]      regM_o_instr,
    output logic [63:0]      regM_o_pc,
    output logic [63:0]      regM_o_valE,
    output logic [63:0]      regM_o_valB,
    output logic [2:0]       regM_o_load_type,
    output logic             regM_o_mem_ren,
    output logic             regM_o_mem_wen,
    output logic [3:0]       regM_o_mem_wmask,
    output logic             regM_o_wb_en,
    output logic [4:0]       regM_o_rd,
    output logic             regM_o_misalign,
    output logic [CNT_W-1:0] regM_o_mem_ops
);

    // Load-type encodings (RISC-V funct3 layout)
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LD  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;
    localparam logic [2:0] LT_LWU = 3'b110;
    localparam logic [3:0] ZERO_BYTE = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] load_len(input logic [2:0] lt);
        case (lt)
            LT_LB, LT_LBU: return 4'd1;
            LT_LH, LT_LHU: return 4'd2;
            LT_LW, LT_LWU: return 4'd4;
            LT_LD:         return 4'd8;
            default:       return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_len(input logic [1:0] st);
        case (st)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] len, input logic [2:0] addr);
        return (len > 4'd1) && ((({1'b0, addr}) & (len - 4'd1)) != 4'd0);
    endfunction

    logic [3:0] acc_len;
    logic       acc_mis;
    logic       cap_ren;
    logic       cap_wen;
    logic       cap_mis;
    logic       cap_wb;
    logic [3:0] cap_wmask;

    // A simultaneous ren/wen request is resolved as a store
    always_comb begin
        acc_len   = 4'd0;
        acc_mis   = 1'b0;
        cap_ren   = 1'b0;
        cap_wen   = 1'b0;
        cap_mis   = 1'b0;
        cap_wb    = 1'b0;
        cap_wmask = ZERO_BYTE;
        if (regE_o_mem_wen) begin
            acc_len = store_len(regE_o_store_type);
        end else if (regE_o_mem_ren) begin
            acc_len = load_len(regE_o_load_type);
        end
        acc_mis   = is_misaligned(acc_len, execute_o_valE[2:0]);
        cap_wen   = regE_o_mem_wen & ~acc_mis;
        cap_ren   = regE_o_mem_ren & ~regE_o_mem_wen & ~acc_mis;
        cap_mis   = acc_mis & (regE_o_mem_ren | regE_o_mem_wen);
        cap_wb    = regE_o_wb_en & ~cap_mis;
        cap_wmask = cap_wen ? store_len(regE_o_store_type) : ZERO_BYTE;
    end

    logic             vld_p1;
    logic [31:0]      instr_p1;
    logic [63:0]      pc_p1;
    logic [63:0]      val_e_p1;
    logic [63:0]      val_b_p1;
    logic [2:0]       load_type_p1;
    logic             mem_ren_p1;
    logic             mem_wen_p1;
    logic [3:0]       wmask_p1;
    logic             wb_en_p1;
    logic [4:0]       rd_p1;
    logic             misalign_p1;
    logic [CNT_W-1:0] mem_ops_p1;

    // Stage boundary: execute -> memory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1       <= 1'b0;
            instr_p1     <= NOP_INSTR;
            pc_p1        <= 64'd0;
            val_e_p1     <= 64'd0;
            val_b_p1     <= 64'd0;
            load_type_p1 <= 3'd0;
            mem_ren_p1   <= 1'b0;
            mem_wen_p1   <= 1'b0;
            wmask_p1     <= ZERO_BYTE;
            wb_en_p1     <= 1'b0;
            rd_p1        <= 5'd0;
            misalign_p1  <= 1'b0;
            mem_ops_p1   <= '0;
        end else if (ctrl_stall_M) begin
            vld_p1 <= vld_p1;
        end else if (ctrl_bubble_M || !regE_o_valid) begin
            vld_p1       <= 1'b0;
            instr_p1     <= NOP_INSTR;
            pc_p1        <= 64'd0;
            val_e_p1     <= 64'd0;
            val_b_p1     <= 64'd0;
            load_type_p1 <= 3'd0;
            mem_ren_p1   <= 1'b0;
            mem_wen_p1   <= 1'b0;
            wmask_p1     <= ZERO_BYTE;
            wb_en_p1     <= 1'b0;
            rd_p1        <= 5'd0;
            misalign_p1  <= 1'b0;
        end else begin
            vld_p1       <= 1'b1;
            instr_p1     <= regE_o_instr;
            pc_p1        <= regE_o_pc;
            val_e_p1     <= execute_o_valE;
            val_b_p1     <= regE_o_valB;
            load_type_p1 <= regE_o_load_type;
            mem_ren_p1   <= cap_ren;
            mem_wen_p1   <= cap_wen;
            wmask_p1     <= cap_wmask;
            wb_en_p1     <= cap_wb;
            rd_p1        <= regE_o_rd;
            misalign_p1  <= cap_mis;
            if (cap_ren || cap_wen) begin
                mem_ops_p1 <= mem_ops_p1 + CNT_ONE;
            end
        end
    end

    assign regM_o_valid     = vld_p1;
    assign regM_o_instr     = instr_p1;
    assign regM_o_pc        = pc_p1;
    assign regM_o_valE      = val_e_p1;
    assign regM_o_valB      = val_b_p1;
    assign regM_o_load_type = load_type_p1;
    assign regM_o_mem_ren   = mem_ren_p1;
    assign regM_o_mem_wen   = mem_wen_p1;
    assign regM_o_mem_wmask = wmask_p1;
    assign regM_o_wb_en     = wb_en_p1;
    assign regM_o_rd        = rd_p1;
    assign regM_o_misalign  = misalign_p1;
    assign regM_o_mem_ops   = mem_ops_p1;

endmodule

// File: tb/tb_pipe_reg_m.sv
// Bench for pipe_reg_m: directed scenarios plus random traffic against a
// behavioural model; a CNT_W=4 copy shares the stimulus to exercise counter wrap.
module tb_pipe_reg_m;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, bubble;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc, e_vale, e_valb;
    logic [2:0]  e_lt;
    logic        e_ren, e_wen;
    logic [1:0]  e_st;
    logic        e_wb;
    logic [4:0]  e_rd;

    logic        m_valid, m_ren, m_wen, m_wb, m_mis;
    logic [31:0] m_instr;
    logic [63:0] m_pc, m_vale, m_valb;
    logic [2:0]  m_lt;
    logic [3:0]  m_wmask;
    logic [4:0]  m_rd;
    logic [31:0] m_ops;

    logic        w_valid, w_ren, w_wen, w_wb, w_mis;
    logic [31:0] w_instr;
    logic [63:0] w_pc, w_vale, w_valb;
    logic [2:0]  w_lt;
    logic [3:0]  w_wmask;
    logic [4:0]  w_rd;
    logic [3:0]  w_ops;

    always #5 clk = ~clk;

    pipe_reg_m #(.NOP_INSTR(NOP), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .ctrl_stall_M(stall), .ctrl_bubble_M(bubble),
        .regE_o_valid(e_valid), .regE_o_instr(e_instr), .regE_o_pc(e_pc),
        .execute_o_valE(e_vale), .regE_o_valB(e_valb), .regE_o_load_type(e_lt),
        .regE_o_mem_ren(e_ren), .regE_o_mem_wen(e_wen), .regE_o_store_type(e_st),
        .regE_o_wb_en(e_wb), .regE_o_rd(e_rd),
        .regM_o_valid(m_valid), .regM_o_instr(m_instr), .regM_o_pc(m_pc),
        .regM_o_valE(m_vale), .regM_o_valB(m_valb), .regM_o_load_type(m_lt),
        .regM_o_mem_ren(m_ren), .regM_o_mem_wen(m_wen), .regM_o_mem_wmask(m_wmask),
        .regM_o_wb_en(m_wb), .regM_o_rd(m_rd), .regM_o_misalign(m_mis),
        .regM_o_mem_ops(m_ops)
    );

    pipe_reg_m #(.NOP_INSTR(NOP), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .ctrl_stall_M(stall), .ctrl_bubble_M(bubble),
        .regE_o_valid(e_valid), .regE_o_instr(e_instr), .regE_o_pc(e_pc),
        .execute_o_valE(e_vale), .regE_o_valB(e_valb), .regE_o_load_type(e_lt),
        .regE_o_mem_ren(e_ren), .regE_o_mem_wen(e_wen), .regE_o_store_type(e_st),
        .regE_o_wb_en(e_wb), .regE_o_rd(e_rd),
        .regM_o_valid(w_valid), .regM_o_instr(w_instr), .regM_o_pc(w_pc),
        .regM_o_valE(w_vale), .regM_o_valB(w_valb), .regM_o_load_type(w_lt),
        .regM_o_mem_ren(w_ren), .regM_o_mem_wen(w_wen), .regM_o_mem_wmask(w_wmask),
        .regM_o_wb_en(w_wb), .regM_o_rd(w_rd), .regM_o_misalign(w_mis),
        .regM_o_mem_ops(w_ops)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected register contents and total accepted-op count
    logic        x_valid, x_ren, x_wen, x_wb, x_mis;
    logic [31:0] x_instr;
    logic [63:0] x_pc, x_vale, x_valb;
    logic [2:0]  x_lt;
    int          x_wmask;
    logic [4:0]  x_rd;
    longint      x_ops;

    task automatic model_clear();
        x_valid = 0; x_instr = NOP; x_pc = 0; x_vale = 0; x_valb = 0; x_lt = 0;
        x_ren = 0; x_wen = 0; x_wmask = 0; x_wb = 0; x_rd = 0; x_mis = 0;
    endtask

    function automatic int access_bytes(input logic ren, input logic wen,
                                        input logic [2:0] lt, input logic [1:0] st);
        int load_bytes [8] = '{1, 2, 4, 8, 1, 2, 4, 0};
        if (wen) return 1 << st;
        if (ren) return load_bytes[lt];
        return 0;
    endfunction

    task automatic model_edge();
        int  len;
        bit  mis;
        if (!rst) begin
            model_clear();
            x_ops = 0;
        end else if (stall) begin
            // hold everything
        end else if (bubble || !e_valid) begin
            model_clear();
        end else begin
            len = access_bytes(e_ren, e_wen, e_lt, e_st);
            mis = (len > 1) && ((e_vale % 64'(len)) != 0);
            x_valid = 1; x_instr = e_instr; x_pc = e_pc; x_vale = e_vale;
            x_valb = e_valb; x_lt = e_lt; x_rd = e_rd;
            x_wen   = e_wen && !mis;
            x_ren   = e_ren && !e_wen && !mis;
            x_mis   = mis && (e_ren || e_wen);
            x_wb    = e_wb && !x_mis;
            x_wmask = x_wen ? len : 0;
            if (x_ren || x_wen) x_ops++;
        end
    endtask

    task automatic check_all();
        chk("valid", m_valid, x_valid);
        chk("instr", m_instr, x_instr);
        chk("pc", m_pc, x_pc);
        chk("valE", m_vale, x_vale);
        chk("valB", m_valb, x_valb);
        chk("load_type", m_lt, x_lt);
        chk("mem_ren", m_ren, x_ren);
        chk("mem_wen", m_wen, x_wen);
        chk("wmask", m_wmask, 64'(x_wmask));
        chk("wb_en", m_wb, x_wb);
        chk("rd", m_rd, x_rd);
        chk("misalign", m_mis, x_mis);
        chk("mem_ops", m_ops, x_ops % (64'd1 << 32));
        chk("mem_ops4", w_ops, x_ops % 16);
        chk("w4_mirror_ren", w_ren, x_ren);
        chk("w4_mirror_wmask", w_wmask, 64'(x_wmask));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic ren, input logic wen,
                         input logic [2:0] lt, input logic [1:0] st,
                         input logic [63:0] vale, input logic wb);
        e_valid = v; e_ren = ren; e_wen = wen; e_lt = lt; e_st = st;
        e_vale = vale; e_wb = wb;
        e_instr = $urandom; e_pc = {$urandom, $urandom};
        e_valb = {$urandom, $urandom}; e_rd = 5'($urandom);
    endtask

    task automatic drive_random();
        drive(($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 3) == 0,
              3'($urandom), 2'($urandom), {$urandom, $urandom}, 1'($urandom));
    endtask

    initial begin
        rst = 0; stall = 0; bubble = 0;
        drive(1, 1, 0, 3'b010, 2'd0, 64'h0, 1);
        model_clear(); x_ops = 0;

        // Reset held three edges, released mid-cycle
        repeat (3) tick();
        chk("rst_instr", m_instr, 64'h13);
        @(negedge clk);
        rst = 1;

        // Aligned sd
        e_valid = 1; e_wen = 1; e_ren = 0; e_st = 2'd3; e_vale = 64'h80001008;
        e_valb = 64'hDEADBEEF_01234567; e_wb = 0;
        tick();
        chk("sd_wen", m_wen, 1);
        chk("sd_wmask", m_wmask, 8);
        chk("sd_valB", m_valb, 64'hDEADBEEF_01234567);
        chk("sd_ops", m_ops, 1);

        // Misaligned lw, then lbu at the same address
        drive(1, 1, 0, 3'b010, 2'd0, 64'h80001002, 1);
        tick();
        chk("lw_mis", m_mis, 1);
        chk("lw_ren", m_ren, 0);
        chk("lw_wb", m_wb, 0);
        chk("lw_ops", m_ops, 1);
        drive(1, 1, 0, 3'b100, 2'd0, 64'h80001002, 1);
        tick();
        chk("lbu_ren", m_ren, 1);
        chk("lbu_mis", m_mis, 0);

        // sh, stall with changing inputs, stall+bubble, bubble
        drive(1, 0, 1, 3'b000, 2'd1, 64'h80002004, 0);
        tick();
        chk("sh_wmask", m_wmask, 2);
        stall = 1;
        repeat (2) begin
            drive_random();
            tick();
        end
        chk("stall_wmask", m_wmask, 2);
        bubble = 1;
        tick();
        chk("stall_bubble_valid", m_valid, 1);
        stall = 0;
        tick();
        chk("bubble_valid", m_valid, 0);
        chk("bubble_instr", m_instr, 64'h13);
        chk("bubble_ops", m_ops, 3);
        bubble = 0;

        // Asynchronous reset between edges, then counter wrap on the 4-bit copy
        rst = 0;
        #1;
        model_clear(); x_ops = 0;
        check_all();
        tick();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 3'b011, 2'd0, 64'h80003000 + 64'(i * 8), 1);
            tick();
            if (i == 14) chk("wrap_15", w_ops, 15);
            if (i == 15) chk("wrap_0", w_ops, 0);
            if (i == 16) chk("wrap_1", w_ops, 1);
        end

        // Async reset during a stalled sw
        drive(1, 0, 1, 3'b000, 2'd2, 64'h80004008, 0);
        tick();
        stall = 1;
        tick();
        #2;
        rst = 0;
        #1;
        chk("arst_instr", m_instr, 64'h13);
        chk("arst_wen", m_wen, 0);
        chk("arst_ops", m_ops, 0);
        model_clear(); x_ops = 0;
        check_all();
        tick();
        @(negedge clk);
        rst = 1;
        stall = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall  = ($urandom % 5) == 0;
            bubble = ($urandom % 6) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
